// File: rtl/model_nexys_pruned_5_dense_pkg.sv
// Shared types and helpers for the dense-layer accumulator.
package model_nexys_pruned_5_dense_pkg;

    // Accumulator FSM states
    typedef enum logic [1:0] {
        ACC,
        RND,
        OUT
    } state_t;

    // Smallest accumulator width that can hold n_terms products plus bias without overflow
    function automatic int acc_width(input int prod_w, input int n_terms);
        return prod_w + $clog2(n_terms) + 1;
    endfunction

    // Largest representable signed value at width w
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    // Smallest representable signed value at width w
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/model_nexys_pruned_5_dense_accum_if.sv
// Product-in / result-out handshake bundle for the dense accumulator.
interface model_nexys_pruned_5_dense_accum_if #(
    parameter int PROD_WIDTH = 23,
    parameter int BIAS_WIDTH = 16,
    parameter int OUT_WIDTH  = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [PROD_WIDTH-1:0] in_prod;
    logic [BIAS_WIDTH-1:0] bias;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  out_data;

    // Upstream multiplier + downstream activation side
    modport master (
        output in_valid, in_prod, bias, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Accumulator side
    modport slave (
        input  in_valid, in_prod, bias, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/model_nexys_pruned_5_dense_round_sat.sv
// Round-half-up, arithmetic shift and saturate an accumulator to output width.
module model_nexys_pruned_5_dense_round_sat
    import model_nexys_pruned_5_dense_pkg::*;
#(
    parameter int ACC_WIDTH = 28,
    parameter int SHIFT     = 8,
    parameter int OUT_WIDTH = 16
) (
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [OUT_WIDTH-1:0] result
);
    // One extra bit so adding the half-LSB can never wrap
    localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH + 1)'(longint'(1) <<< (SHIFT - 1));
    localparam logic signed [ACC_WIDTH:0] MAXV = (ACC_WIDTH + 1)'(sat_max(OUT_WIDTH));
    localparam logic signed [ACC_WIDTH:0] MINV = (ACC_WIDTH + 1)'(sat_min(OUT_WIDTH));

    logic signed [ACC_WIDTH:0] sum;
    logic signed [ACC_WIDTH:0] r;

    // Round toward +inf on ties, then clamp into the signed output range
    always_comb begin
        sum = {acc[ACC_WIDTH-1], acc} + HALF;
        r   = sum >>> SHIFT;
        if (r > MAXV)
            result = MAXV[OUT_WIDTH-1:0];
        else if (r < MINV)
            result = MINV[OUT_WIDTH-1:0];
        else
            result = r[OUT_WIDTH-1:0];
    end
endmodule

// File: rtl/model_nexys_pruned_5_dense_accum.sv
// Dense-layer neuron accumulator: bias + N_TERMS products, rounded and saturated.
module model_nexys_pruned_5_dense_accum
    import model_nexys_pruned_5_dense_pkg::*;
#(
    parameter int PROD_WIDTH = 23,
    parameter int N_TERMS    = 16,
    parameter int BIAS_WIDTH = 16,
    parameter int ACC_WIDTH  = acc_width(PROD_WIDTH, N_TERMS),
    parameter int SHIFT      = 8,
    parameter int OUT_WIDTH  = 16
) (
    input logic clk,
    input logic reset,
    model_nexys_pruned_5_dense_accum_if.slave bus
);
    localparam int                CNT_W = $clog2(N_TERMS);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N_TERMS - 1);

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic [OUT_WIDTH-1:0]        rs_out;
    logic [OUT_WIDTH-1:0]        out_data_r;
    logic                        out_valid_r;
    logic                        take;

    assign prod_ext = ACC_WIDTH'($signed(bus.in_prod));
    assign bias_ext = ACC_WIDTH'($signed(bus.bias));

    // Accept only in ACC; no dependence on out_ready
    assign bus.in_ready  = (state == ACC);
    assign take          = bus.in_valid && (state == ACC);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;

    model_nexys_pruned_5_dense_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_round_sat (
        .acc    (acc),
        .result (rs_out)
    );

    // Group FSM: accumulate N_TERMS products, register rounded result, hold until taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ACC;
            cnt         <= '0;
            acc         <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (take) begin
                        // Bias only joins the sum on the first term of a group
                        acc <= (cnt == '0) ? bias_ext + prod_ext : acc + prod_ext;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= RND;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RND: begin
                    out_data_r  <= rs_out;
                    out_valid_r <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (out_valid_r && bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_model_nexys_pruned_5_dense_accum.sv
// Directed + randomized bench for the dense accumulator (N_TERMS=4, SHIFT=8).
module tb_model_nexys_pruned_5_dense_accum;
    localparam int PW = 23;
    localparam int NT = 4;
    localparam int BW = 16;
    localparam int SH = 8;
    localparam int OW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   total  = 0;

    model_nexys_pruned_5_dense_accum_if #(
        .PROD_WIDTH (PW),
        .BIAS_WIDTH (BW),
        .OUT_WIDTH  (OW)
    ) bus ();

    model_nexys_pruned_5_dense_accum #(
        .PROD_WIDTH (PW),
        .N_TERMS    (NT),
        .BIAS_WIDTH (BW),
        .SHIFT      (SH),
        .OUT_WIDTH  (OW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: exact integer sum, floor((s + half) / 2^SH), clamp to output range
    function automatic longint ref_out(input longint b, input longint p [NT]);
        longint s;
        longint q;
        longint lo;
        longint hi;
        s = b;
        foreach (p[i]) s += p[i];
        s += longint'(1) << (SH - 1);
        if (s >= 0) q = s / (longint'(1) << SH);
        else        q = -((-s + (longint'(1) << SH) - 1) / (longint'(1) << SH));
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -(longint'(1) << (OW - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    function automatic longint rnd_bias();
        return longint'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Present one product at a negedge and return at the negedge after it is taken
    task automatic accept(input longint p, input longint b);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_prod  = PW'(p);
        bus.bias     = BW'(b);
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = bus.in_ready;
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 64'(ok), 1);
        bus.in_valid = 1'b0;
    endtask

    // Idle cycles with junk on the data lines
    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_prod  = PW'($urandom);
        bus.bias     = BW'($urandom);
        repeat (n) @(negedge clk);
    endtask

    // Called right after the last accept: one RND cycle, then the result
    task automatic expect_result(input string tag, input longint exp);
        check({tag, "_rnd_valid"}, 64'(bus.out_valid), 0);
        check({tag, "_rnd_ready"}, 64'(bus.in_ready), 0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(bus.out_valid), 1);
        check({tag, "_data"}, 64'($signed(bus.out_data)), exp);
        check({tag, "_out_ready"}, 64'(bus.in_ready), 0);
        if (bus.out_ready) begin
            @(negedge clk);
            check({tag, "_drop"}, 64'(bus.out_valid), 0);
            check({tag, "_rdy"}, 64'(bus.in_ready), 1);
        end
    endtask

    task automatic run_group(input string tag, input longint b, input longint p [NT],
                             input int gmin, input int gmax, input longint exp);
        for (int i = 0; i < NT; i++) begin
            accept(p[i], (i == 0) ? b : rnd_bias());
            if (i < NT - 1 && gmax > 0) idle($urandom_range(gmin, gmax));
        end
        expect_result(tag, exp);
    endtask

    // Asynchronous pulse between clock edges; effect must be visible before any edge
    task automatic reset_pulse(input string tag);
        #2 reset = 1'b0;
        #1;
        check({tag, "_valid"}, 64'(bus.out_valid), 0);
        check({tag, "_ready"}, 64'(bus.in_ready), 1);
        check({tag, "_data"}, 64'($signed(bus.out_data)), 0);
        #1 reset = 1'b1;
        @(negedge clk);
        check({tag, "_post_ready"}, 64'(bus.in_ready), 1);
    endtask

    initial begin
        longint pv [NT];
        longint b;

        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.bias      = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_ready", 64'(bus.in_ready), 1);
        check("reset_valid", 64'(bus.out_valid), 0);
        check("reset_data", 64'($signed(bus.out_data)), 0);
        reset = 1'b1;
        @(negedge clk);

        pv = '{256, 256, 256, 256};
        run_group("basic", 0, pv, 0, 0, 4);

        pv = '{128, 0, 0, 0};
        run_group("rnd_p128", 0, pv, 0, 0, 1);
        pv = '{127, 0, 0, 0};
        run_group("rnd_p127", 0, pv, 0, 0, 0);
        pv = '{-128, 0, 0, 0};
        run_group("rnd_m128", 0, pv, 0, 0, 0);
        pv = '{-129, 0, 0, 0};
        run_group("rnd_m129", 0, pv, 0, 0, -1);

        pv = '{0, 0, 0, 0};
        run_group("bias512", 512, pv, 0, 0, 2);
        pv = '{4194303, 4194303, 4194303, 4194303};
        run_group("sat_pos", 0, pv, 0, 0, 32767);
        pv = '{-4194304, -4194304, -4194304, -4194304};
        run_group("sat_neg", 0, pv, 0, 0, -32768);

        // Backpressure: result held, new product on the bus must not be taken
        bus.out_ready = 1'b0;
        pv = '{256, 256, 256, 256};
        run_group("bp_first", 0, pv, 0, 0, 4);
        bus.in_valid = 1'b1;
        bus.in_prod  = PW'(1000);
        bus.bias     = BW'(300);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(bus.out_valid), 1);
            check("bp_hold_data", 64'($signed(bus.out_data)), 4);
            check("bp_hold_ready", 64'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(bus.out_valid), 0);
        check("bp_release_ready", 64'(bus.in_ready), 1);
        accept(1000, 300);
        accept(2000, rnd_bias());
        accept(-500, rnd_bias());
        accept(700, rnd_bias());
        expect_result("bp_next", 14);

        pv = '{100, 200, 300, 400};
        run_group("gaps", 24, pv, 1, 3, 4);

        // Reset mid-group discards the partial sum
        accept(256, 0);
        accept(256, rnd_bias());
        reset_pulse("rst_mid");
        pv = '{256, 256, 256, 256};
        run_group("rst_mid_next", 0, pv, 0, 0, 4);

        // Reset while a result is waiting
        bus.out_ready = 1'b0;
        pv = '{128, 0, 0, 0};
        run_group("rst_ov_pre", 0, pv, 0, 0, 1);
        reset_pulse("rst_ov");
        bus.out_ready = 1'b1;
        pv = '{-1000, 300, 0, 50};
        run_group("rst_ov_next", 7, pv, 0, 0, ref_out(7, pv));

        // Randomized groups against the reference model
        for (int g = 0; g < 10; g++) begin
            b = rnd_bias();
            for (int i = 0; i < NT; i++) begin
                if (g % 3 == 0) pv[i] = longint'($urandom_range(0, 8388607)) - 4194304;
                else            pv[i] = longint'($urandom_range(0, 131071)) - 65536;
            end
            run_group("rand", b, pv, 0, 2, ref_out(b, pv));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog so the bench can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
